uart_autobaud: RTL



---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_edge.sv | 35 +++
 rtl/uart_autobaud.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART auto-baud path.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARMED      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_MEASURE    = 3'd3,
        ST_STOP_CHK   = 3'd4,
        ST_LOCKED     = 3'd5,
        ST_ERROR      = 3'd6
    } state_t;

    // 0x55 sent LSB first gives falling edges at 0, 2T, 4T, 6T and 8T.
    localparam logic [7:0] SYNC_CHAR   = 8'h55;
    localparam int         SYNC_FALLS  = 5;

    localparam int         DIV_W       = 16;

    // total = 8T, so (total + 64) >> 7 = round(T / 16).
    localparam int         ROUND_ADD   = 64;
    localparam int         ROUND_SHIFT = 7;

endpackage

// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for an idle-high async line plus a registered
// falling-edge pulse. Every edge sees the same 3-clk latency.
module uart_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_fall;

    // Sync chain resets to the idle-high level so reset release never
    // produces a spurious falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_fall <= r_prev & ~r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_fall;

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud detector: times a 0x55 sync character on the RX line and
// produces the 16x-oversampling divisor for the baud generator.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | after reset, waiting for arm
// ARMED       | counting continuous idle-high clocks on the line
// WAIT_START  | line proven idle, waiting for the start-bit falling edge
// MEASURE     | timing edge-to-edge intervals across the five falling edges
// STOP_CHK    | waiting to mid-stop-bit, then sampling for framing
// LOCKED      | divisor loaded, holds until arm
// ERROR       | interval, timeout, framing or range failure, holds until arm
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int CNT_W    = 24,
    parameter int IDLE_MIN = 16,
    parameter int TIMEOUT  = 1048575
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             arm,
    output logic [DIV_W-1:0] divisor,
    output logic             div_valid,
    output logic             locked,
    output logic             err,
    output logic             busy
);

    localparam logic [CNT_W-1:0] C_IDLE_MIN = CNT_W'(IDLE_MIN);
    localparam logic [CNT_W-1:0] C_TIMEOUT  = CNT_W'(TIMEOUT);

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t           r_state;
    state_t           r_state_nxt;
    logic [CNT_W-1:0] r_idle;
    logic [CNT_W-1:0] r_idle_nxt;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_total_nxt;
    logic [CNT_W-1:0] r_interval;
    logic [CNT_W-1:0] r_interval_nxt;
    logic [CNT_W-1:0] r_ref;
    logic [CNT_W-1:0] r_ref_nxt;
    logic [2:0]       r_edge;
    logic [2:0]       r_edge_nxt;
    logic [DIV_W-1:0] r_divisor;
    logic [DIV_W-1:0] r_divisor_nxt;
    logic             r_div_valid;
    logic             r_div_valid_nxt;

    logic             w_line;
    logic             w_fall;
    logic [CNT_W-1:0] w_idle_inc;
    logic [CNT_W-1:0] w_tot_inc;
    logic [CNT_W-1:0] w_int_inc;
    logic [2:0]       w_edge_inc;
    logic [CNT_W-1:0] w_diff;
    logic [CNT_W-1:0] w_tol;
    logic             w_in_tol;
    logic [CNT_W+1:0] w_ref3;
    logic             w_at_sample;
    logic [CNT_W:0]   w_div_sum;
    logic [CNT_W:0]   w_div_wide;
    logic             w_div_zero;
    logic             w_div_ovf;

    uart_sync_edge u_sync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (serial_in),
        .o_sync  (w_line),
        .o_fall  (w_fall)
    );

    // Intervals are counted including the current cycle, so an edge 2T after
    // the previous one reports exactly 2T.
    assign w_idle_inc = f_sat_inc(r_idle);
    assign w_tot_inc  = f_sat_inc(r_total);
    assign w_int_inc  = f_sat_inc(r_interval);
    assign w_edge_inc = r_edge + 3'd1;

    assign w_diff     = (w_int_inc >= r_ref) ? (w_int_inc - r_ref) : (r_ref - w_int_inc);
    assign w_tol      = r_ref >> 3;
    assign w_in_tol   = (w_diff <= w_tol);

    // Reference is 2T, so (3R)>>2 lands at 1.5T past the last falling edge,
    // the middle of the stop bit.
    assign w_ref3      = {2'b00, r_ref} + {1'b0, r_ref, 1'b0};
    assign w_at_sample = ({2'b00, w_int_inc} >= (w_ref3 >> 2));

    assign w_div_sum  = {1'b0, r_total} + (CNT_W+1)'(ROUND_ADD);
    assign w_div_wide = w_div_sum >> ROUND_SHIFT;
    assign w_div_zero = (w_div_wide == '0);
    assign w_div_ovf  = |w_div_wide[CNT_W:DIV_W];

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idle      <= '0;
            r_total     <= '0;
            r_interval  <= '0;
            r_ref       <= '0;
            r_edge      <= '0;
            r_divisor   <= '0;
            r_div_valid <= 1'b0;
        end else begin
            r_state     <= r_state_nxt;
            r_idle      <= r_idle_nxt;
            r_total     <= r_total_nxt;
            r_interval  <= r_interval_nxt;
            r_ref       <= r_ref_nxt;
            r_edge      <= r_edge_nxt;
            r_divisor   <= r_divisor_nxt;
            r_div_valid <= r_div_valid_nxt;
        end
    end

    // Next-state and datapath update; arm overrides everything and restarts.
    always_comb begin
        r_state_nxt     = r_state;
        r_idle_nxt      = r_idle;
        r_total_nxt     = r_total;
        r_interval_nxt  = r_interval;
        r_ref_nxt       = r_ref;
        r_edge_nxt      = r_edge;
        r_divisor_nxt   = r_divisor;
        r_div_valid_nxt = 1'b0;

        if (arm) begin
            r_state_nxt    = ST_ARMED;
            r_idle_nxt     = '0;
            r_total_nxt    = '0;
            r_interval_nxt = '0;
            r_ref_nxt      = '0;
            r_edge_nxt     = '0;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_line) begin
                        r_idle_nxt = w_idle_inc;
                        if (w_idle_inc >= C_IDLE_MIN) begin
                            r_state_nxt = ST_WAIT_START;
                        end
                    end else begin
                        r_idle_nxt = '0;
                    end
                end

                ST_WAIT_START: begin
                    if (w_fall) begin
                        r_total_nxt    = '0;
                        r_interval_nxt = '0;
                        r_edge_nxt     = 3'd1;
                        r_state_nxt    = ST_MEASURE;
                    end
                end

                ST_MEASURE: begin
                    r_total_nxt = w_tot_inc;
                    if (w_fall) begin
                        r_edge_nxt     = w_edge_inc;
                        r_interval_nxt = '0;
                        if (w_edge_inc == 3'd2) begin
                            r_ref_nxt = w_int_inc;
                        end else if (!w_in_tol) begin
                            r_state_nxt = ST_ERROR;
                        end else if (w_edge_inc == 3'(SYNC_FALLS)) begin
                            r_state_nxt = ST_STOP_CHK;
                        end
                    end else if (w_int_inc > C_TIMEOUT) begin
                        r_state_nxt = ST_ERROR;
                    end else begin
                        r_interval_nxt = w_int_inc;
                    end
                end

                ST_STOP_CHK: begin
                    r_interval_nxt = w_int_inc;
                    if (w_at_sample) begin
                        if (!w_line || w_div_zero || w_div_ovf) begin
                            r_state_nxt = ST_ERROR;
                        end else begin
                            r_divisor_nxt   = w_div_wide[DIV_W-1:0];
                            r_div_valid_nxt = 1'b1;
                            r_state_nxt     = ST_LOCKED;
                        end
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign divisor   = r_divisor;
    assign div_valid = r_div_valid;
    assign locked    = (r_state == ST_LOCKED);
    assign err       = (r_state == ST_ERROR);
    assign busy      = (r_state == ST_ARMED)   || (r_state == ST_WAIT_START) ||
                       (r_state == ST_MEASURE) || (r_state == ST_STOP_CHK);

endmodule
